// File: rtl/booth_radix4_mult.sv
// Radix-4 (modified) Booth multiplier with integrated start/busy/done controller.
// Optional unsigned mode is enabled by defining BOOTH_UNSIGNED_EN (adds is_signed input).
module booth_radix4_mult #(
  parameter int N  = 8,
  parameter int CW = $clog2(N/2+2)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
`ifdef BOOTH_UNSIGNED_EN
  input  logic           is_signed,
`endif
  input  logic [N-1:0]   data_M,
  input  logic [N-1:0]   data_Q,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] data_out
);

  localparam int AW = N + 2;
`ifdef BOOTH_UNSIGNED_EN
  localparam int QW = N + 2;
`else
  localparam int QW = N;
`endif

  if ((N % 2) != 0 || N < 4) begin : g_bad_width
    $error("booth_radix4_mult: N must be even and >= 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   a_reg, m_reg, addend, sum, a_shift;
  logic [QW-1:0]   q_reg, q_shift;
  logic            qm1;
  logic [CW-1:0]   count;
  logic [AW-1:0]   m_load;
  logic [QW-1:0]   q_load;
  logic [CW-1:0]   count_load;
  logic [2*N-1:0]  product;

`ifdef BOOTH_UNSIGNED_EN
  logic            uns_reg;

  // Unsigned operands are zero-extended and need one extra digit pair to clear their top bit.
  always_comb begin
    m_load     = is_signed ? {{2{data_M[N-1]}}, data_M} : {2'b00, data_M};
    q_load     = is_signed ? {{2{data_Q[N-1]}}, data_Q} : {2'b00, data_Q};
    count_load = is_signed ? CW'(N/2) : CW'(N/2 + 1);
  end

  assign product = uns_reg ? {a_shift[N-3:0], q_shift}
                           : {a_shift[N-1:0], q_shift[QW-1:2]};
`else
  always_comb begin
    m_load     = {{2{data_M[N-1]}}, data_M};
    q_load     = data_Q;
    count_load = CW'(N/2);
  end

  assign product = {a_shift[N-1:0], q_shift};
`endif

  always_comb begin
    addend = '0;
    case ({q_reg[1:0], qm1})
      3'b001, 3'b010: addend = m_reg;
      3'b011:         addend = {m_reg[AW-2:0], 1'b0};
      3'b100:         addend = ~{m_reg[AW-2:0], 1'b0} + AW'(1);
      3'b101, 3'b110: addend = ~m_reg + AW'(1);
      default:        addend = '0;
    endcase
  end

  assign sum     = a_reg + addend;
  assign a_shift = {{2{sum[AW-1]}}, sum[AW-1:2]};
  assign q_shift = {sum[1:0], q_reg[QW-1:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (count == CW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Operands are captured only on the accepted start; the product register moves only on the last iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      m_reg    <= '0;
      q_reg    <= '0;
      qm1      <= 1'b0;
      count    <= '0;
      data_out <= '0;
`ifdef BOOTH_UNSIGNED_EN
      uns_reg  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= '0;
            m_reg   <= m_load;
            q_reg   <= q_load;
            qm1     <= 1'b0;
            count   <= count_load;
`ifdef BOOTH_UNSIGNED_EN
            uns_reg <= ~is_signed;
`endif
          end
        end
        RUN: begin
          a_reg <= a_shift;
          q_reg <= q_shift;
          qm1   <= q_reg[1];
          count <= count - CW'(1);
          if (count == CW'(1)) data_out <= product;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Directed table plus corner sequences for booth_radix4_mult (N=8 and an N=16 instance).
// Define BOOTH_UNSIGNED_EN to also exercise the unsigned mode.
module tb_booth_radix4_mult;

  localparam int N  = 8;
  localparam int N2 = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [N-1:0]    data_M = '0;
  logic [N-1:0]    data_Q = '0;
  logic            busy, done;
  logic [2*N-1:0]  data_out;
  logic            is_signed = 1'b1;

  logic            start16 = 1'b0;
  logic [N2-1:0]   m16 = '0;
  logic [N2-1:0]   q16 = '0;
  logic            busy16, done16;
  logic [2*N2-1:0] out16;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string          name;
    logic [N-1:0]   m;
    logic [N-1:0]   q;
    logic           sgn;
    logic [2*N-1:0] p;
    int             cyc;
  } vec_t;

  vec_t vecs[$];

  booth_radix4_mult #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef BOOTH_UNSIGNED_EN
    .is_signed(is_signed),
`endif
    .data_M(data_M), .data_Q(data_Q),
    .busy(busy), .done(done), .data_out(data_out)
  );

  booth_radix4_mult #(.N(N2)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16),
`ifdef BOOTH_UNSIGNED_EN
    .is_signed(1'b1),
`endif
    .data_M(m16), .data_Q(q16),
    .busy(busy16), .done(done16), .data_out(out16)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // One multiply on the N=8 unit; operands are scrambled right after acceptance.
  task automatic applyStimulus(input string name, input logic [N-1:0] m, input logic [N-1:0] q,
                               input logic sgn, input logic [2*N-1:0] exp_p, input int exp_busy);
    int             busy_cycles = 0;
    int             done_cycles = 0;
    bit             hold_ok = 1'b1;
    bit             finished = 1'b0;
    logic [2*N-1:0] held;
    @(posedge clk); #1;
    data_M = m; data_Q = q; is_signed = sgn; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; data_M = N'($urandom); data_Q = N'($urandom); is_signed = 1'($urandom);
    held = data_out;
    for (int c = 0; c < 40 && !finished; c++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        done_cycles++;
        held = data_out;
      end else if (data_out !== held) hold_ok = 1'b0;
      if (!busy) finished = 1'b1;
    end
    checkOutput({name, " busy_cycles"}, busy_cycles, exp_busy);
    checkOutput({name, " done_pulses"}, done_cycles, 1);
    checkOutput({name, " data_out_hold"}, hold_ok, 1);
    checkOutput({name, " product"}, data_out, exp_p);
  endtask

  task automatic apply16(input logic [N2-1:0] m, input logic [N2-1:0] q, input logic [2*N2-1:0] exp_p);
    bit seen = 1'b0;
    @(posedge clk); #1;
    m16 = m; q16 = q; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0; m16 = N2'($urandom);
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (done16) seen = 1'b1;
    end
    checkOutput("n16 done_seen", seen, 1);
    checkOutput("n16 product", out16, exp_p);
  endtask

  initial begin
    logic signed [N-1:0]    rm, rq;
    logic signed [2*N-1:0]  rp;
    logic signed [N2-1:0]   sm, sq;
    logic signed [2*N2-1:0] sp;
    logic [N-1:0]           bm [3];
    logic [N-1:0]           bq [3];
    logic [2*N-1:0]         bp [3];
    int acc, got, last_done;
    bit prev_busy, quiet;

    vecs.push_back('{"m7q3",       8'd7,   8'd3,   1'b1, 16'h0015, 5});
    vecs.push_back('{"m-128q-128", 8'h80,  8'h80,  1'b1, 16'h4000, 5});
    vecs.push_back('{"m-128q127",  8'h80,  8'h7F,  1'b1, 16'hC080, 5});
    vecs.push_back('{"m-5q3",      8'hFB,  8'd3,   1'b1, 16'hFFF1, 5});
    vecs.push_back('{"m127q127",   8'h7F,  8'h7F,  1'b1, 16'h3F01, 5});
    vecs.push_back('{"m-1q-1",     8'hFF,  8'hFF,  1'b1, 16'h0001, 5});
    vecs.push_back('{"m0q-1",      8'h00,  8'hFF,  1'b1, 16'h0000, 5});
    vecs.push_back('{"m1q-128",    8'h01,  8'h80,  1'b1, 16'hFF80, 5});

    #2;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset data_out", data_out, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      applyStimulus(vecs[i].name, vecs[i].m, vecs[i].q, vecs[i].sgn, vecs[i].p, vecs[i].cyc);

    // Abort in the middle of a multiply; data_out currently holds 16'hFF80.
    @(posedge clk); #1;
    data_M = 8'd7; data_Q = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort done", done, 0);
    checkOutput("abort data_out", data_out, 0);
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done || busy || data_out !== '0) quiet = 1'b0;
    end
    checkOutput("abort quiet", quiet, 1);
    rst_n = 1'b1;
    applyStimulus("post_reset m0q-1", 8'h00, 8'hFF, 1'b1, 16'h0000, 5);
    applyStimulus("post_reset m7q3", 8'd7, 8'd3, 1'b1, 16'h0015, 5);

    // start held high across three operand pairs.
    bm[0] = 8'd7;  bq[0] = 8'd3;  bp[0] = 16'h0015;
    bm[1] = 8'hFB; bq[1] = 8'd3;  bp[1] = 16'hFFF1;
    bm[2] = 8'h80; bq[2] = 8'h80; bp[2] = 16'h4000;
    @(posedge clk); #1;
    data_M = bm[0]; data_Q = bq[0]; is_signed = 1'b1; start = 1'b1;
    acc = 0; got = 0; last_done = 0; prev_busy = busy;
    for (int c = 0; c < 60 && got < 3; c++) begin
      @(negedge clk);
      if (busy && !prev_busy) begin
        acc++;
        if (acc < 3) begin
          data_M = bm[acc]; data_Q = bq[acc];
        end else start = 1'b0;
      end
      if (done) begin
        checkOutput($sformatf("b2b product%0d", got), data_out, bp[got]);
        if (got > 0) checkOutput($sformatf("b2b spacing%0d", got), c - last_done, 6);
        last_done = c;
        got++;
      end
      prev_busy = busy;
    end
    start = 1'b0;
    checkOutput("b2b products", got, 3);
    checkOutput("b2b accepted", acc, 3);
    quiet = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done) quiet = 1'b0;
    end
    checkOutput("b2b no_extra_done", quiet, 1);

    for (int i = 0; i < 150; i++) begin
      rm = N'($urandom); rq = N'($urandom);
      rp = rm * rq;
      applyStimulus("rand8", rm, rq, 1'b1, rp, 5);
    end

    for (int i = 0; i < 100; i++) begin
      sm = N2'($urandom); sq = N2'($urandom);
      sp = sm * sq;
      apply16(sm, sq, sp);
    end
    apply16(16'h8000, 16'h8000, 32'h4000_0000);

`ifdef BOOTH_UNSIGNED_EN
    applyStimulus("uns m255q255", 8'hFF, 8'hFF, 1'b0, 16'hFE01, 6);
    applyStimulus("sgn m255q255", 8'hFF, 8'hFF, 1'b1, 16'h0001, 5);
    applyStimulus("uns m128q3",   8'h80, 8'd3,  1'b0, 16'h0180, 6);
    applyStimulus("uns m200q100", 8'd200, 8'd100, 1'b0, 16'h4E20, 6);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
